// File: rtl/decode_stage.sv
//------------------------------------------------------------------------------
// Module      : decode_stage
// Description : RV64 decode stage with RAW scoreboard, writeback bypass and a
//               registered valid/ready output bundle toward execute.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module decode_stage #(
   parameter  int REG_DATA_WIDTH_POW = 6,
   parameter  int REG_MEM_DEPTH_POW  = 5,
   localparam int c_XLEN             = 1 << REG_DATA_WIDTH_POW,
   localparam int c_AW               = REG_MEM_DEPTH_POW
) (
   input  logic              clk_in,
   input  logic              rst_in,
   // fetch side
   input  logic [31:0]       instr_in,
   input  logic [c_XLEN-1:0] pc_in,
   input  logic              instr_valid_in,
   output logic              instr_ready_out,
   // register file read ports
   output logic [c_AW-1:0]   rs1_out,
   output logic [c_AW-1:0]   rs2_out,
   input  logic [c_XLEN-1:0] reg_data1_in,
   input  logic [c_XLEN-1:0] reg_data2_in,
   // writeback
   input  logic              wb_retire_in,
   input  logic              wb_en_in,
   input  logic [c_AW-1:0]   wb_rd_in,
   input  logic [c_XLEN-1:0] wb_data_in,
   input  logic              flush_in,
   // execute side
   output logic              ex_valid_out,
   input  logic              ex_ready_in,
   output logic [c_XLEN-1:0] ex_pc_out,
   output logic [c_XLEN-1:0] ex_rs1_data_out,
   output logic [c_XLEN-1:0] ex_rs2_data_out,
   output logic [c_XLEN-1:0] ex_imm_out,
   output logic [c_AW-1:0]   ex_rd_out,
   output logic [6:0]        ex_opcode_out,
   output logic [2:0]        ex_funct3_out,
   output logic [6:0]        ex_funct7_out,
   output logic              ex_wr_en_out,
   output logic              ex_illegal_out
);

   localparam int         c_NREGS       = 1 << REG_MEM_DEPTH_POW;
   localparam logic [6:0] c_OP_LUI      = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] c_OP_JAL      = 7'b1101111;
   localparam logic [6:0] c_OP_JALR     = 7'b1100111;
   localparam logic [6:0] c_OP_LOAD     = 7'b0000011;
   localparam logic [6:0] c_OP_IMM      = 7'b0010011;
   localparam logic [6:0] c_OP_IMM_32   = 7'b0011011;
   localparam logic [6:0] c_OP_STORE    = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] c_OP_OP       = 7'b0110011;
   localparam logic [6:0] c_OP_OP_32    = 7'b0111011;

   // ---------------------------------------------------------------- fields
   logic [6:0]        w_opcode;
   logic [c_AW-1:0]   w_rd;
   logic [2:0]        w_funct3;
   logic [c_AW-1:0]   w_rs1;
   logic [c_AW-1:0]   w_rs2;
   logic [6:0]        w_funct7;

   assign w_opcode = instr_in[6:0];
   assign w_rd     = instr_in[11:7];
   assign w_funct3 = instr_in[14:12];
   assign w_rs1    = instr_in[19:15];
   assign w_rs2    = instr_in[24:20];
   assign w_funct7 = instr_in[31:25];

   assign rs1_out = w_rs1;
   assign rs2_out = w_rs2;

   // ------------------------------------------------------ format decoding
   logic w_fmt_u, w_fmt_j, w_fmt_i, w_fmt_s, w_fmt_b, w_fmt_r, w_illegal;

   always_comb begin
      w_fmt_u   = 1'b0;
      w_fmt_j   = 1'b0;
      w_fmt_i   = 1'b0;
      w_fmt_s   = 1'b0;
      w_fmt_b   = 1'b0;
      w_fmt_r   = 1'b0;
      w_illegal = 1'b0;
      case (w_opcode)
         c_OP_LUI, c_OP_AUIPC:                       w_fmt_u   = 1'b1;
         c_OP_JAL:                                   w_fmt_j   = 1'b1;
         c_OP_JALR, c_OP_LOAD, c_OP_IMM, c_OP_IMM_32: w_fmt_i   = 1'b1;
         c_OP_STORE:                                 w_fmt_s   = 1'b1;
         c_OP_BRANCH:                                w_fmt_b   = 1'b1;
         c_OP_OP, c_OP_OP_32:                        w_fmt_r   = 1'b1;
         default:                                    w_illegal = 1'b1;
      endcase
   end

   logic w_uses_rs1, w_uses_rs2, w_writes_rd;

   assign w_uses_rs1  = w_fmt_i | w_fmt_s | w_fmt_b | w_fmt_r;
   assign w_uses_rs2  = w_fmt_s | w_fmt_b | w_fmt_r;
   assign w_writes_rd = (w_fmt_u | w_fmt_j | w_fmt_i | w_fmt_r) && (w_rd != '0);

   // ------------------------------------------------------------ immediate
   logic [c_XLEN-1:0] w_imm;

   always_comb begin
      w_imm = '0;
      if (w_fmt_u) begin
         w_imm = {{(c_XLEN-32){instr_in[31]}}, instr_in[31:12], 12'b0};
      end else if (w_fmt_j) begin
         w_imm = {{(c_XLEN-21){instr_in[31]}}, instr_in[31], instr_in[19:12],
                  instr_in[20], instr_in[30:21], 1'b0};
      end else if (w_fmt_i) begin
         w_imm = {{(c_XLEN-12){instr_in[31]}}, instr_in[31:20]};
      end else if (w_fmt_s) begin
         w_imm = {{(c_XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      end else if (w_fmt_b) begin
         w_imm = {{(c_XLEN-13){instr_in[31]}}, instr_in[31], instr_in[7],
                  instr_in[30:25], instr_in[11:8], 1'b0};
      end
   end

   // ------------------------------------------------------ output register
   logic              r_ex_valid;
   logic [c_XLEN-1:0] r_ex_pc;
   logic [c_XLEN-1:0] r_ex_rs1_data;
   logic [c_XLEN-1:0] r_ex_rs2_data;
   logic [c_XLEN-1:0] r_ex_imm;
   logic [c_AW-1:0]   r_ex_rd;
   logic [6:0]        r_ex_opcode;
   logic [2:0]        r_ex_funct3;
   logic [6:0]        r_ex_funct7;
   logic              r_ex_wr_en;
   logic              r_ex_illegal;
   logic [c_NREGS-1:0] r_pending;

   // -------------------------------------------------- hazard and bypass
   // A retiring writer clears its hazard, unless the bundle still sitting in
   // the output register is itself a newer writer of the same register.
   function automatic logic f_src_hazard(
      input logic               used,
      input logic [c_AW-1:0]    rs,
      input logic [c_NREGS-1:0] pending,
      input logic               out_wr,
      input logic [c_AW-1:0]    out_rd,
      input logic               retire,
      input logic [c_AW-1:0]    ret_rd
   );
      logic out_match;
      logic ret_match;
      out_match = out_wr && (out_rd == rs);
      ret_match = retire && (ret_rd == rs);
      return used && (rs != '0) && (out_match || (pending[rs] && !ret_match));
   endfunction

   function automatic logic [c_XLEN-1:0] f_operand(
      input logic [c_AW-1:0]   rs,
      input logic [c_XLEN-1:0] rf_data,
      input logic              wen,
      input logic [c_AW-1:0]   wrd,
      input logic [c_XLEN-1:0] wdata
   );
      if (rs == '0)                 return '0;
      else if (wen && (wrd == rs))  return wdata;
      else                          return rf_data;
   endfunction

   logic w_out_wr;
   logic w_haz_rs1, w_haz_rs2, w_stall;
   logic w_accept, w_handoff;

   assign w_out_wr  = r_ex_valid && r_ex_wr_en;
   assign w_haz_rs1 = f_src_hazard(w_uses_rs1, w_rs1, r_pending, w_out_wr, r_ex_rd,
                                   wb_retire_in, wb_rd_in);
   assign w_haz_rs2 = f_src_hazard(w_uses_rs2, w_rs2, r_pending, w_out_wr, r_ex_rd,
                                   wb_retire_in, wb_rd_in);
   assign w_stall   = w_haz_rs1 || w_haz_rs2;

   assign instr_ready_out = !rst_in && !flush_in && !w_stall && (!r_ex_valid || ex_ready_in);
   assign w_accept        = instr_valid_in && instr_ready_out;
   assign w_handoff       = r_ex_valid && ex_ready_in;

   // ----------------------------------------------------------- scoreboard
   logic [c_NREGS-1:0] w_pending_nxt;

   always_comb begin
      w_pending_nxt = r_pending;
      if (wb_retire_in) begin
         w_pending_nxt[wb_rd_in] = 1'b0;
      end
      // set after clear so a same-register collision leaves the bit set
      if (w_handoff && r_ex_wr_en) begin
         w_pending_nxt[r_ex_rd] = 1'b1;
      end
      w_pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pending_nxt;
      end
   end

   // -------------------------------------------------------- bundle update
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_ex_valid    <= 1'b0;
         r_ex_pc       <= '0;
         r_ex_rs1_data <= '0;
         r_ex_rs2_data <= '0;
         r_ex_imm      <= '0;
         r_ex_rd       <= '0;
         r_ex_opcode   <= '0;
         r_ex_funct3   <= '0;
         r_ex_funct7   <= '0;
         r_ex_wr_en    <= 1'b0;
         r_ex_illegal  <= 1'b0;
      end else if (w_accept) begin
         r_ex_valid    <= 1'b1;
         r_ex_pc       <= pc_in;
         r_ex_rs1_data <= f_operand(w_rs1, reg_data1_in, wb_en_in, wb_rd_in, wb_data_in);
         r_ex_rs2_data <= f_operand(w_rs2, reg_data2_in, wb_en_in, wb_rd_in, wb_data_in);
         r_ex_imm      <= w_imm;
         r_ex_rd       <= w_rd;
         r_ex_opcode   <= w_opcode;
         r_ex_funct3   <= w_funct3;
         r_ex_funct7   <= w_funct7;
         r_ex_wr_en    <= w_writes_rd;
         r_ex_illegal  <= w_illegal;
      end else if (ex_ready_in || flush_in) begin
         r_ex_valid    <= 1'b0;
      end
   end

   assign ex_valid_out    = r_ex_valid;
   assign ex_pc_out       = r_ex_pc;
   assign ex_rs1_data_out = r_ex_rs1_data;
   assign ex_rs2_data_out = r_ex_rs2_data;
   assign ex_imm_out      = r_ex_imm;
   assign ex_rd_out       = r_ex_rd;
   assign ex_opcode_out   = r_ex_opcode;
   assign ex_funct3_out   = r_ex_funct3;
   assign ex_funct7_out   = r_ex_funct7;
   assign ex_wr_en_out    = r_ex_wr_en;
   assign ex_illegal_out  = r_ex_illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] instr_in;
   logic [63:0] pc_in;
   logic        instr_valid_in;
   logic        instr_ready_out;
   logic [4:0]  rs1_out, rs2_out;
   logic [63:0] reg_data1_in, reg_data2_in;
   logic        wb_retire_in, wb_en_in;
   logic [4:0]  wb_rd_in;
   logic [63:0] wb_data_in;
   logic        flush_in;
   logic        ex_valid_out, ex_ready_in;
   logic [63:0] ex_pc_out, ex_rs1_data_out, ex_rs2_data_out, ex_imm_out;
   logic [4:0]  ex_rd_out;
   logic [6:0]  ex_opcode_out;
   logic [2:0]  ex_funct3_out;
   logic [6:0]  ex_funct7_out;
   logic        ex_wr_en_out, ex_illegal_out;

   int n_vec = 0;
   int n_err = 0;

   decode_stage dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .instr_in        (instr_in),
      .pc_in           (pc_in),
      .instr_valid_in  (instr_valid_in),
      .instr_ready_out (instr_ready_out),
      .rs1_out         (rs1_out),
      .rs2_out         (rs2_out),
      .reg_data1_in    (reg_data1_in),
      .reg_data2_in    (reg_data2_in),
      .wb_retire_in    (wb_retire_in),
      .wb_en_in        (wb_en_in),
      .wb_rd_in        (wb_rd_in),
      .wb_data_in      (wb_data_in),
      .flush_in        (flush_in),
      .ex_valid_out    (ex_valid_out),
      .ex_ready_in     (ex_ready_in),
      .ex_pc_out       (ex_pc_out),
      .ex_rs1_data_out (ex_rs1_data_out),
      .ex_rs2_data_out (ex_rs2_data_out),
      .ex_imm_out      (ex_imm_out),
      .ex_rd_out       (ex_rd_out),
      .ex_opcode_out   (ex_opcode_out),
      .ex_funct3_out   (ex_funct3_out),
      .ex_funct7_out   (ex_funct7_out),
      .ex_wr_en_out    (ex_wr_en_out),
      .ex_illegal_out  (ex_illegal_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // advance past the next rising edge; outputs are sampled 1 ns later
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_in = 1'b1;  instr_in = '0;  pc_in = '0;  instr_valid_in = 1'b0;
      reg_data1_in = '0;  reg_data2_in = '0;
      wb_retire_in = 1'b0;  wb_en_in = 1'b0;  wb_rd_in = '0;  wb_data_in = '0;
      flush_in = 1'b0;  ex_ready_in = 1'b0;
      tick();
      tick();
      chk("rst_ready", {63'd0, instr_ready_out}, 64'd0);
      chk("rst_valid", {63'd0, ex_valid_out}, 64'd0);
      chk("rst_imm", ex_imm_out, 64'd0);

      // ADDI x1,x0,5
      rst_in = 1'b0;
      instr_in = 32'h0050_0093;  pc_in = 64'h1000;  instr_valid_in = 1'b1;
      ex_ready_in = 1'b1;  reg_data1_in = 64'h1111;  reg_data2_in = 64'h2222;
      settle();
      chk("addi_ready", {63'd0, instr_ready_out}, 64'd1);
      chk("addi_rs2_out", {59'd0, rs2_out}, 64'd5);
      tick();
      chk("addi_valid", {63'd0, ex_valid_out}, 64'd1);
      chk("addi_rd", {59'd0, ex_rd_out}, 64'd1);
      chk("addi_imm", ex_imm_out, 64'd5);
      chk("addi_wr_en", {63'd0, ex_wr_en_out}, 64'd1);
      chk("addi_rs1_data", ex_rs1_data_out, 64'd0);
      chk("addi_pc", ex_pc_out, 64'h1000);
      chk("addi_opcode", {57'd0, ex_opcode_out}, 64'h13);

      // ADD x2,x1,x1 stalls until x1 retires, then takes the bypassed value
      instr_in = 32'h0010_8133;  pc_in = 64'h1004;
      settle();
      chk("add_stall_outreg", {63'd0, instr_ready_out}, 64'd0);
      chk("add_rs1_out", {59'd0, rs1_out}, 64'd1);
      tick();
      chk("addi_handed_off", {63'd0, ex_valid_out}, 64'd0);
      chk("add_stall_pend0", {63'd0, instr_ready_out}, 64'd0);
      tick();
      chk("add_stall_pend1", {63'd0, instr_ready_out}, 64'd0);
      wb_retire_in = 1'b1;  wb_en_in = 1'b1;  wb_rd_in = 5'd1;  wb_data_in = 64'h2A;
      settle();
      chk("add_ready_on_wb", {63'd0, instr_ready_out}, 64'd1);
      tick();
      wb_retire_in = 1'b0;  wb_en_in = 1'b0;  wb_rd_in = '0;  wb_data_in = '0;
      chk("add_valid", {63'd0, ex_valid_out}, 64'd1);
      chk("add_rs1_bypass", ex_rs1_data_out, 64'h2A);
      chk("add_rs2_bypass", ex_rs2_data_out, 64'h2A);
      chk("add_rd", {59'd0, ex_rd_out}, 64'd2);
      chk("add_imm", ex_imm_out, 64'd0);

      // BEQ x0,x0,-4
      instr_in = 32'hFE00_0EE3;  pc_in = 64'h1008;
      settle();
      chk("beq_ready", {63'd0, instr_ready_out}, 64'd1);
      tick();
      chk("beq_imm", ex_imm_out, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("beq_wr_en", {63'd0, ex_wr_en_out}, 64'd0);

      // Backpressure: hold BEQ for 3 cycles while ADDI x3,x0,7 waits
      ex_ready_in = 1'b0;
      instr_in = 32'h0070_0193;  pc_in = 64'h100C;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_ready", {63'd0, instr_ready_out}, 64'd0);
         tick();
         chk("bp_valid", {63'd0, ex_valid_out}, 64'd1);
         chk("bp_imm", ex_imm_out, 64'hFFFF_FFFF_FFFF_FFFC);
         chk("bp_pc", ex_pc_out, 64'h1008);
      end
      ex_ready_in = 1'b1;
      settle();
      chk("bp_release_ready", {63'd0, instr_ready_out}, 64'd1);
      tick();
      chk("addi3_rd", {59'd0, ex_rd_out}, 64'd3);
      chk("addi3_imm", ex_imm_out, 64'd7);
      chk("addi3_pc", ex_pc_out, 64'h100C);

      // Illegal opcode 0x7F with rd field 5; ADDI x3 hands off (pending[3])
      instr_in = 32'h0000_02FF;  pc_in = 64'h1010;
      settle();
      chk("ill_ready", {63'd0, instr_ready_out}, 64'd1);
      tick();
      chk("ill_flag", {63'd0, ex_illegal_out}, 64'd1);
      chk("ill_wr_en", {63'd0, ex_wr_en_out}, 64'd0);
      chk("ill_imm", ex_imm_out, 64'd0);

      // Flush the illegal bundle, then ADD x6,x5,x0 must not stall
      ex_ready_in = 1'b0;  flush_in = 1'b1;
      instr_in = 32'h0002_8333;  pc_in = 64'h1014;
      reg_data1_in = 64'h55;  reg_data2_in = 64'h99;
      settle();
      chk("flush_ready", {63'd0, instr_ready_out}, 64'd0);
      tick();
      chk("flush_valid", {63'd0, ex_valid_out}, 64'd0);
      flush_in = 1'b0;  ex_ready_in = 1'b1;
      settle();
      chk("x5_not_pending", {63'd0, instr_ready_out}, 64'd1);
      tick();
      chk("add6_rs1", ex_rs1_data_out, 64'h55);
      chk("add6_rs2_x0", ex_rs2_data_out, 64'd0);
      chk("add6_rd", {59'd0, ex_rd_out}, 64'd6);

      // ADD x7,x3,x0 stalls on pending[3], kept across the flush
      instr_in = 32'h0001_83B3;  pc_in = 64'h1018;
      settle();
      chk("x3_pending", {63'd0, instr_ready_out}, 64'd0);
      tick();
      chk("x3_pending_2", {63'd0, instr_ready_out}, 64'd0);

      // Asynchronous reset mid-stall
      rst_in = 1'b1;
      settle();
      chk("mid_rst_valid", {63'd0, ex_valid_out}, 64'd0);
      chk("mid_rst_pc", ex_pc_out, 64'd0);
      chk("mid_rst_rs1", ex_rs1_data_out, 64'd0);
      chk("mid_rst_ready", {63'd0, instr_ready_out}, 64'd0);
      tick();
      rst_in = 1'b0;
      settle();
      chk("post_rst_ready", {63'd0, instr_ready_out}, 64'd1);
      tick();
      chk("post_rst_valid", {63'd0, ex_valid_out}, 64'd1);
      chk("post_rst_rd", {59'd0, ex_rd_out}, 64'd7);

      // LUI x8,0x80000
      instr_in = 32'h8000_0437;  pc_in = 64'h2000;
      tick();
      chk("lui_imm", ex_imm_out, 64'hFFFF_FFFF_8000_0000);
      chk("lui_rd", {59'd0, ex_rd_out}, 64'd8);

      // SD x0,-8(x0)
      instr_in = 32'hFE00_3C23;  pc_in = 64'h2004;
      tick();
      chk("sd_imm", ex_imm_out, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("sd_funct3", {61'd0, ex_funct3_out}, 64'd3);
      chk("sd_wr_en", {63'd0, ex_wr_en_out}, 64'd0);

      // ADDI x0,x0,1: rd = 0 never writes
      instr_in = 32'h0010_0013;  pc_in = 64'h2008;
      tick();
      chk("x0_wr_en", {63'd0, ex_wr_en_out}, 64'd0);
      chk("x0_imm", ex_imm_out, 64'd1);

      instr_valid_in = 1'b0;
      tick();
      chk("drain_valid", {63'd0, ex_valid_out}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
